// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory req/ack, decode valid/ready and
// branch redirect from execute. The master modport is the fetch unit's view.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        dec_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        branch_en;
  logic [31:0] branch_pc;
  logic [31:0] branch_offset;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_ack, imem_rdata, dec_ready, branch_en, branch_pc, branch_offset
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_ack, imem_rdata, dec_ready, branch_en, branch_pc, branch_offset
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one word request in flight and
// hands each fetched instruction to decode; branch redirects win everywhere.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_t;

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] instr_reg;
  logic [31:0] instr_pc_reg;
  logic        req_reg;
  logic        valid_reg;

  logic [31:0] target_sum;
  logic [31:0] target;

  assign target_sum = bus.branch_pc + 32'd8 + bus.branch_offset;
  assign target     = {target_sum[31:2], 2'b00};

  // req_reg/valid_reg always mirror (state==REQ)/(state==HOLD) of the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      pc_reg       <= RESET_PC_ALIGNED;
      instr_reg    <= 32'h0;
      instr_pc_reg <= 32'h0;
      req_reg      <= 1'b0;
      valid_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.branch_en) pc_reg <= target;
          state_reg <= REQ;
          req_reg   <= 1'b1;
        end
        REQ: begin
          if (bus.branch_en) begin
            pc_reg <= target;
            // With a simultaneous ack the slot is free, so reissue at once
            if (!bus.imem_ack) begin
              state_reg <= DROP;
              req_reg   <= 1'b0;
            end
          end else if (bus.imem_ack) begin
            instr_reg    <= bus.imem_rdata;
            instr_pc_reg <= pc_reg;
            pc_reg       <= pc_reg + 32'd4;
            state_reg    <= HOLD;
            req_reg      <= 1'b0;
            valid_reg    <= 1'b1;
          end
        end
        HOLD: begin
          if (bus.branch_en) begin
            pc_reg    <= target;
            state_reg <= REQ;
            req_reg   <= 1'b1;
            valid_reg <= 1'b0;
          end else if (bus.dec_ready) begin
            state_reg <= REQ;
            req_reg   <= 1'b1;
            valid_reg <= 1'b0;
          end
        end
        DROP: begin
          if (bus.branch_en) pc_reg <= target;
          if (bus.imem_ack) begin
            state_reg <= REQ;
            req_reg   <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          req_reg   <= 1'b0;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req    = req_reg;
  assign bus.imem_addr   = {pc_reg[31:2], 2'b00};
  assign bus.instr_valid = valid_reg;
  assign bus.instr       = instr_reg;
  assign bus.instr_pc    = instr_pc_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: hand-driven memory acks, decode ready and
// branch redirects, with expected values worked out per cycle.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0; bus.dec_ready = 1'b0;
    bus.branch_en = 1'b0; bus.branch_pc = 32'h0; bus.branch_offset = 32'h0;
    reset = 1'b1;
    tick; tick;
    if (bus.imem_req !== 1'b0) begin $display("FAIL reset_req got=%b want=0", bus.imem_req); bad++; end total++;
    if (bus.instr_valid !== 1'b0) begin $display("FAIL reset_valid got=%b want=0", bus.instr_valid); bad++; end total++;
    if (bus.instr !== 32'h0) begin $display("FAIL reset_instr got=%h want=00000000", bus.instr); bad++; end total++;
    if (bus.instr_pc !== 32'h0) begin $display("FAIL reset_instr_pc got=%h want=00000000", bus.instr_pc); bad++; end total++;
    if (bus.imem_addr !== 32'h100) begin $display("FAIL reset_addr got=%h want=00000100", bus.imem_addr); bad++; end total++;
    reset = 1'b0;
    $display("reset released, idle cycle req=%b", bus.imem_req);
  endtask

  task automatic test_first_fetch;
    tick;
    if (bus.imem_req !== 1'b1) begin $display("FAIL first_req got=%b want=1", bus.imem_req); bad++; end total++;
    if (bus.imem_addr !== 32'h100) begin $display("FAIL first_addr got=%h want=00000100", bus.imem_addr); bad++; end total++;
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hE3A0_1001;
    tick;
    bus.imem_ack = 1'b0;
    if (bus.instr_valid !== 1'b1) begin $display("FAIL first_valid got=%b want=1", bus.instr_valid); bad++; end total++;
    if (bus.instr !== 32'hE3A0_1001) begin $display("FAIL first_instr got=%h want=e3a01001", bus.instr); bad++; end total++;
    if (bus.instr_pc !== 32'h100) begin $display("FAIL first_instr_pc got=%h want=00000100", bus.instr_pc); bad++; end total++;
    if (bus.imem_req !== 1'b0) begin $display("FAIL first_req_hold got=%b want=0", bus.imem_req); bad++; end total++;
    bus.dec_ready = 1'b1;
    tick;
    bus.dec_ready = 1'b0;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h104) begin
      $display("FAIL first_next_req got=%b/%h want=1/00000104", bus.imem_req, bus.imem_addr); bad++;
    end total++;
    if (bus.instr_valid !== 1'b0) begin $display("FAIL first_valid_drop got=%b want=0", bus.instr_valid); bad++; end total++;
    $display("first fetch: instr_pc=100 next addr=%h", bus.imem_addr);
  endtask

  task automatic test_stall;
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hE281_1002;
    tick;
    bus.imem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      // a protocol-violating ack in HOLD must be ignored
      if (i == 2) begin bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF; end
      tick;
      bus.imem_ack = 1'b0;
      if (bus.instr_valid !== 1'b1 || bus.instr !== 32'hE281_1002 || bus.instr_pc !== 32'h104) begin
        $display("FAIL stall_hold[%0d] got=%b/%h/%h want=1/e2811002/00000104", i, bus.instr_valid, bus.instr, bus.instr_pc); bad++;
      end total++;
      if (bus.imem_req !== 1'b0) begin $display("FAIL stall_req[%0d] got=%b want=0", i, bus.imem_req); bad++; end total++;
    end
    bus.dec_ready = 1'b1;
    tick;
    bus.dec_ready = 1'b0;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h108) begin
      $display("FAIL stall_release got=%b/%h want=1/00000108", bus.imem_req, bus.imem_addr); bad++;
    end total++;
    $display("stall: 5 cycles held, released to addr=%h", bus.imem_addr);
  endtask

  task automatic test_branch_hold;
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hEA00_0010;
    tick;
    bus.imem_ack = 1'b0;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h108) begin
      $display("FAIL bhold_pre got=%b/%h want=1/00000108", bus.instr_valid, bus.instr_pc); bad++;
    end total++;
    bus.branch_en = 1'b1; bus.branch_pc = 32'h200; bus.branch_offset = 32'hFFFF_FFF8; bus.dec_ready = 1'b1;
    tick;
    bus.branch_en = 1'b0; bus.dec_ready = 1'b0;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin
      $display("FAIL bhold_target got=%b/%h want=1/00000200", bus.imem_req, bus.imem_addr); bad++;
    end total++;
    if (bus.instr_valid !== 1'b0) begin $display("FAIL bhold_valid got=%b want=0", bus.instr_valid); bad++; end total++;
    $display("branch in hold: next addr=%h", bus.imem_addr);
  endtask

  task automatic test_branch_wait;
    bus.branch_en = 1'b1; bus.branch_pc = 32'h3F8; bus.branch_offset = 32'h0;
    tick;
    bus.branch_en = 1'b0;
    if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin
      $display("FAIL bwait_drop1 got=%b/%b want=0/0", bus.imem_req, bus.instr_valid); bad++;
    end total++;
    tick;
    if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin
      $display("FAIL bwait_drop2 got=%b/%b want=0/0", bus.imem_req, bus.instr_valid); bad++;
    end total++;
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hBAD0_BAD0;
    tick;
    bus.imem_ack = 1'b0;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h400 || bus.instr_valid !== 1'b0) begin
      $display("FAIL bwait_after got=%b/%h/%b want=1/00000400/0", bus.imem_req, bus.imem_addr, bus.instr_valid); bad++;
    end total++;
    $display("branch during wait: stale dropped, addr=%h", bus.imem_addr);
  endtask

  task automatic test_drop_last_branch;
    bus.branch_en = 1'b1; bus.branch_pc = 32'h4F8; bus.branch_offset = 32'h0;
    tick;
    bus.branch_pc = 32'h5F8;
    if (bus.imem_req !== 1'b0) begin $display("FAIL lastb_drop got=%b want=0", bus.imem_req); bad++; end total++;
    tick;
    bus.branch_en = 1'b0;
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hBAD1_BAD1;
    tick;
    bus.imem_ack = 1'b0;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h600) begin
      $display("FAIL lastb_target got=%b/%h want=1/00000600", bus.imem_req, bus.imem_addr); bad++;
    end total++;
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hE080_0001;
    tick;
    bus.imem_ack = 1'b0;
    if (bus.instr_valid !== 1'b1 || bus.instr !== 32'hE080_0001 || bus.instr_pc !== 32'h600) begin
      $display("FAIL lastb_fetch got=%b/%h/%h want=1/e0800001/00000600", bus.instr_valid, bus.instr, bus.instr_pc); bad++;
    end total++;
    bus.dec_ready = 1'b1;
    tick;
    bus.dec_ready = 1'b0;
    $display("last branch in drop wins: fetched 600, next addr=%h", bus.imem_addr);
  endtask

  task automatic test_same_cycle;
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1234_5678;
    bus.branch_en = 1'b1; bus.branch_pc = 32'h601; bus.branch_offset = 32'h10;
    tick;
    bus.imem_ack = 1'b0; bus.branch_en = 1'b0;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h618) begin
      $display("FAIL same_target got=%b/%h want=1/00000618", bus.imem_req, bus.imem_addr); bad++;
    end total++;
    if (bus.instr_valid !== 1'b0) begin $display("FAIL same_valid got=%b want=0", bus.instr_valid); bad++; end total++;
    $display("same-cycle branch+ack: addr=%h", bus.imem_addr);
  endtask

  task automatic test_wrap;
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0; 
    bus.branch_en = 1'b1; bus.branch_pc = 32'hFFFF_FFF4; bus.branch_offset = 32'h0;
    tick;
    bus.branch_en = 1'b0; bus.imem_rdata = 32'hE1A0_0000;
    if (bus.imem_addr !== 32'hFFFF_FFFC) begin $display("FAIL wrap_addr got=%h want=fffffffc", bus.imem_addr); bad++; end total++;
    tick;
    bus.imem_ack = 1'b0;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'hFFFF_FFFC) begin
      $display("FAIL wrap_fetch got=%b/%h want=1/fffffffc", bus.instr_valid, bus.instr_pc); bad++;
    end total++;
    bus.dec_ready = 1'b1;
    tick;
    bus.dec_ready = 1'b0;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      $display("FAIL wrap_next got=%b/%h want=1/00000000", bus.imem_req, bus.imem_addr); bad++;
    end total++;
    $display("wrap: next addr=%h", bus.imem_addr);
  endtask

  task automatic test_reset_mid;
    reset = 1'b1;
    tick;
    if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.imem_addr !== 32'h100 ||
        bus.instr !== 32'h0 || bus.instr_pc !== 32'h0) begin
      $display("FAIL midreset got=%b/%b/%h/%h/%h want=0/0/00000100/00000000/00000000",
               bus.imem_req, bus.instr_valid, bus.imem_addr, bus.instr, bus.instr_pc); bad++;
    end total++;
    reset = 1'b0;
    bus.branch_en = 1'b1; bus.branch_pc = 32'h7F8; bus.branch_offset = 32'h0;
    tick;
    bus.branch_en = 1'b0;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h800) begin
      $display("FAIL idle_branch got=%b/%h want=1/00000800", bus.imem_req, bus.imem_addr); bad++;
    end total++;
    $display("reset mid-request, idle branch: addr=%h", bus.imem_addr);
  endtask

  task automatic test_back_to_back;
    logic [31:0] word;
    bus.imem_ack = 1'b1; bus.dec_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      word = 32'hA000_0000 + 32'(i);
      bus.imem_rdata = word;
      tick;
      if (bus.instr_valid !== 1'b1 || bus.instr !== word || bus.instr_pc !== 32'h800 + 32'(4 * i)) begin
        $display("FAIL b2b_hold[%0d] got=%b/%h/%h want=1/%h/%h", i, bus.instr_valid, bus.instr, bus.instr_pc, word, 32'h800 + 32'(4 * i)); bad++;
      end total++;
      tick;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h804 + 32'(4 * i) || bus.instr_valid !== 1'b0) begin
        $display("FAIL b2b_req[%0d] got=%b/%h/%b want=1/%h/0", i, bus.imem_req, bus.imem_addr, bus.instr_valid, 32'h804 + 32'(4 * i)); bad++;
      end total++;
      $display("back-to-back %0d: instr_pc=%h", i, 32'h800 + 32'(4 * i));
    end
    bus.imem_ack = 1'b0; bus.dec_ready = 1'b0;
  endtask

  initial begin
    test_reset;
    test_first_fetch;
    test_stall;
    test_branch_hold;
    test_branch_wait;
    test_drop_last_branch;
    test_same_cycle;
    test_wrap;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
